act_fetch_sequencer: RTL and testbench

// - Upstream feeder of the systolic data staging stage: reads activation rows from the unified buffer
//   and presents one LANES-wide vector per cycle on read_o/data_o, with read_o leading data_o by 1 cycle.
// - Sequences a job (base address, row count), honours stall_i, then drains the array skew before done_o.

---
 rtl/act_fetch_sequencer.sv | 168 ++++++++++++++++
 tb/tb_act_fetch_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/act_fetch_sequencer.sv
// act_fetch_sequencer: streams activation rows out of the unified buffer,
// one LANES-wide vector per cycle, then waits out the staging diagonal skew
// before signalling job completion.
// Optional feature macro: ACT_FETCH_STRIDE_EN (adds stride_i, a latched
// per-job address step; without it the step is fixed at 1).

// Per-lane return mux: pass buffer data only when a read is returning.
module act_fetch_lane #(
   parameter int DATA_W = 16
) (
   input  logic              i_vld,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data
);
   assign o_data = i_vld ? i_data : '0;
endmodule

module act_fetch_sequencer #(
   parameter int DATA_W = 16,
   parameter int LANES  = 32,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 11
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [ADDR_W-1:0]             base_addr_i,
   input  logic [CNT_W-1:0]              num_rows_i,
`ifdef ACT_FETCH_STRIDE_EN
   input  logic [ADDR_W-1:0]             stride_i,
`endif
   input  logic                          stall_i,
   output logic                          ub_rd_en_o,
   output logic [ADDR_W-1:0]             ub_rd_addr_o,
   input  logic [LANES-1:0][DATA_W-1:0]  ub_rd_data_i,
   output logic                          read_o,
   output logic [LANES-1:0][DATA_W-1:0]  data_o,
   output logic                          busy_o,
   output logic                          done_o
);

   // Drain counter must hold the value LANES itself.
   localparam int DR_W = $clog2(LANES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_remain;
   logic [DR_W-1:0]   r_drain;
   logic              r_busy;
   logic              r_done;
   logic              r_rd_vld;
   logic              w_issue;
   logic              w_accept;
   logic [ADDR_W-1:0] w_step;

   // A start is only honoured while idle; everything else ignores it.
   assign w_accept = (r_state == S_IDLE) && start_i;

   // A row goes out every unstalled FETCH cycle while rows remain.
   assign w_issue = (r_state == S_FETCH) && !stall_i && (r_remain != '0);

   assign ub_rd_en_o   = w_issue;
   assign read_o       = w_issue;
   assign ub_rd_addr_o = r_addr;
   assign busy_o       = r_busy;
   assign done_o       = r_done;

`ifdef ACT_FETCH_STRIDE_EN
   logic [ADDR_W-1:0] r_stride;

   // Stride is captured with the job so later input changes do not disturb it.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_stride <= '0;
      else if (w_accept)
         r_stride <= stride_i;
   end

   assign w_step = r_stride;
`else
   assign w_step = ADDR_W'(1);
`endif

   // Job sequencer: latch job, issue rows, drain skew, pulse done.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_remain <= '0;
         r_drain  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_addr   <= base_addr_i;
                  r_remain <= num_rows_i;
                  r_busy   <= 1'b1;
                  if (num_rows_i == '0) begin
                     // Empty job: no reads, straight to the done pulse.
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (w_issue) begin
                  // Address wraps modulo 2^ADDR_W by natural truncation.
                  r_addr   <= r_addr + w_step;
                  r_remain <= r_remain - CNT_W'(1);
                  if (r_remain == CNT_W'(1)) begin
                     r_state <= S_DRAIN;
                     r_drain <= DR_W'(LANES);
                  end
               end
            end
            S_DRAIN: begin
               // Covers the last row return plus LANES-1 diagonal skew
               // cycles; stall has no effect here.
               r_drain <= r_drain - DR_W'(1);
               if (r_drain == DR_W'(1)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // In-flight return flag: buffer data is valid one cycle after issue.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_rd_vld <= 1'b0;
      else
         r_rd_vld <= w_issue;
   end

   genvar g;
   for (g = 0; g < LANES; g++) begin : g_lane
      act_fetch_lane #(.DATA_W(DATA_W)) u_lane (
         .i_vld  (r_rd_vld),
         .i_data (ub_rd_data_i[g]),
         .o_data (data_o[g])
      );
   end

endmodule

// File: tb/tb_act_fetch_sequencer.sv
// Bench for act_fetch_sequencer: directed job table, reset-abort sequence
// and randomized jobs against an arithmetic schedule model.
module tb_act_fetch_sequencer;
   localparam int DATA_W = 16;
   localparam int LANES  = 32;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 11;
   localparam int VW     = DATA_W * LANES;
   localparam int TM     = 1200;

   logic clk = 1'b0;
   logic rst, start, stall;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  rows;
`ifdef ACT_FETCH_STRIDE_EN
   logic [ADDR_W-1:0] stride_in;
`endif
   logic en, rd, busy, done;
   logic [ADDR_W-1:0] addr;
   logic [LANES-1:0][DATA_W-1:0] ubd = '0;
   logic [LANES-1:0][DATA_W-1:0] dout;

   int checks = 0;
   int failures = 0;
   int cur_t = 0;

   always #5 clk = ~clk;

   act_fetch_sequencer #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .num_rows_i(rows),
`ifdef ACT_FETCH_STRIDE_EN
      .stride_i(stride_in),
`endif
      .stall_i(stall), .ub_rd_en_o(en), .ub_rd_addr_o(addr), .ub_rd_data_i(ubd),
      .read_o(rd), .data_o(dout), .busy_o(busy), .done_o(done)
   );

   // Buffer contents are a known function of address and lane.
   function automatic logic [LANES-1:0][DATA_W-1:0] row_of(input logic [ADDR_W-1:0] a);
      logic [LANES-1:0][DATA_W-1:0] r;
      for (int l = 0; l < LANES; l++) r[l] = {a, 5'(l), 1'b1};
      return r;
   endfunction

   // Unified buffer: 1-cycle read latency, random junk when not read.
   always @(posedge clk) begin
      if (en) ubd <= row_of(addr);
      else for (int l = 0; l < LANES; l++) ubd[l] <= 16'($urandom);
   end

   task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0d got=%h exp=%h", nm, cur_t, got, exp);
      end
   endtask

   // Runs one job. Model: k-th issue lands on the k-th unstalled cycle after
   // start at base+k*stride; done = last issue + 1 + LANES (or 1 if empty).
   task automatic run_job(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n,
                          input logic [ADDR_W-1:0] s, input logic [TM-1:0] sp, input bit noise,
                          output int dcyc, output int nis, output logic [ADDR_W-1:0] last);
      bit een[TM];
      logic [ADDR_W-1:0] ead[TM];
      int k, lst, d;
      for (int t = 0; t < TM; t++) begin een[t] = 1'b0; ead[t] = '0; end
      k = 0; lst = 0;
      for (int t = 1; t < TM; t++)
         if (k < int'(n) && !sp[t]) begin
            een[t] = 1'b1; ead[t] = ADDR_W'(int'(b) + k * int'(s)); k++; lst = t;
         end
      d = (n == 0) ? 1 : lst + 1 + LANES;
      dcyc = -1; nis = 0; last = '0;
      for (int t = 0; t <= d + 1; t++) begin
         @(posedge clk); #1;
         if (t == 0) begin
            start = 1'b1; base = b; rows = n;
`ifdef ACT_FETCH_STRIDE_EN
            stride_in = s;
`endif
         end else begin
            start = (noise && t <= d) ? 1'($urandom) : 1'b0;
            if (noise) begin
               base = ADDR_W'($urandom); rows = CNT_W'($urandom);
`ifdef ACT_FETCH_STRIDE_EN
               stride_in = ADDR_W'($urandom);
`endif
            end
         end
         stall = sp[t];
         @(negedge clk); cur_t = t;
         chk("ub_rd_en", VW'(en), VW'(een[t]));
         chk("read_o", VW'(rd), VW'(een[t]));
         if (een[t]) chk("ub_rd_addr", VW'(addr), VW'(ead[t]));
         chk("data_o", dout, (t > 0 && een[t-1]) ? row_of(ead[t-1]) : '0);
         chk("busy_o", VW'(busy), VW'(t >= 1 && t <= d));
         chk("done_o", VW'(done), VW'(t == d));
         if (done && dcyc < 0) dcyc = t;
         if (en) begin nis++; last = addr; end
      end
      start = 1'b0; stall = 1'b0;
   endtask

   typedef struct {
      logic [ADDR_W-1:0] base;
      logic [CNT_W-1:0]  rows;
      logic [ADDR_W-1:0] stride;
      int                st_s;
      int                st_l;
      bit                noise;
      int                exp_done;
      int                exp_nis;
      logic [ADDR_W-1:0] exp_last;
   } vec_t;

   initial begin
      vec_t vt[$];
      logic [TM-1:0] sp;
      int dcyc, nis;
      logic [ADDR_W-1:0] last, rb;
      logic [CNT_W-1:0] rn;
      logic [ADDR_W-1:0] rs;
      bit seen;

      vt.push_back('{10'h010, 11'd4, 10'd1, 0, 0, 1'b0, 37, 4, 10'h013});
      vt.push_back('{10'h010, 11'd4, 10'd1, 3, 3, 1'b0, 40, 4, 10'h013});
      vt.push_back('{10'h3FE, 11'd3, 10'd1, 0, 0, 1'b1, 36, 3, 10'h000});
      vt.push_back('{10'h055, 11'd0, 10'd1, 0, 0, 1'b0, 1, 0, 10'h000});
      vt.push_back('{10'h3FF, 11'd1, 10'd1, 0, 0, 1'b1, 34, 1, 10'h3FF});
      vt.push_back('{10'h100, 11'd2, 10'd1, 1, 2, 1'b1, 37, 2, 10'h101});
      vt.push_back('{10'h200, 11'd1024, 10'd1, 0, 0, 1'b0, 1057, 1024, 10'h1FF});
`ifdef ACT_FETCH_STRIDE_EN
      vt.push_back('{10'h000, 11'd3, 10'd4, 0, 0, 1'b1, 36, 3, 10'h008});
      vt.push_back('{10'h123, 11'd3, 10'd0, 2, 1, 1'b1, 37, 3, 10'h123});
      stride_in = '0;
`endif

      rst = 1'b1; start = 1'b0; base = '0; rows = '0; stall = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_en", VW'(en), '0);
      chk("rst_read", VW'(rd), '0);
      chk("rst_busy", VW'(busy), '0);
      chk("rst_done", VW'(done), '0);
      chk("rst_addr", VW'(addr), '0);
      chk("rst_data", dout, '0);
      @(posedge clk); #1 rst = 1'b0;

      foreach (vt[i]) begin
         sp = '0;
         for (int t = vt[i].st_s; t < vt[i].st_s + vt[i].st_l; t++) sp[t] = 1'b1;
         run_job(vt[i].base, vt[i].rows, vt[i].stride, sp, vt[i].noise, dcyc, nis, last);
         chk($sformatf("vec%0d_done_cycle", i), VW'(dcyc), VW'(vt[i].exp_done));
         chk($sformatf("vec%0d_issues", i), VW'(nis), VW'(vt[i].exp_nis));
         if (vt[i].exp_nis > 0) chk($sformatf("vec%0d_last_addr", i), VW'(last), VW'(vt[i].exp_last));
      end

      // Reset after two issues: job abandoned, in-flight return discarded.
      @(posedge clk); #1 start = 1'b1; base = 10'h020; rows = 11'd4;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk); cur_t = 3;
      chk("prerst_issue", VW'(en), VW'(1'b1));
      chk("prerst_addr", VW'(addr), VW'(10'h022));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); cur_t = 4;
      chk("postrst_en", VW'(en), '0);
      chk("postrst_read", VW'(rd), '0);
      chk("postrst_busy", VW'(busy), '0);
      chk("postrst_done", VW'(done), '0);
      chk("postrst_addr", VW'(addr), '0);
      chk("postrst_data", dout, '0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy || en) seen = 1'b1;
      end
      chk("postrst_quiet", VW'(seen), '0);

      for (int j = 0; j < 25; j++) begin
         rb = ADDR_W'($urandom);
         rn = CNT_W'($urandom_range(0, 24));
`ifdef ACT_FETCH_STRIDE_EN
         rs = ADDR_W'($urandom_range(0, 7));
`else
         rs = ADDR_W'(1);
`endif
         sp = '0;
         for (int t = 1; t <= 3 * int'(rn); t++) sp[t] = ($urandom_range(0, 3) == 0);
         run_job(rb, rn, rs, sp, 1'($urandom), dcyc, nis, last);
         chk("rand_issues", VW'(nis), VW'(rn));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
